// File: rtl/mem_resp_model.sv
// mem_resp_model
//
// Memory-side responder for a MemIO master. It stands in for DRAM behind the
// tag cache: it accepts a line command, then either absorbs REFILL_CYCLES
// write beats into an internal word array or streams REFILL_CYCLES read beats
// back after a fixed latency. Only one transaction is in flight at a time.
//
// Ports:
//   clk, reset               clock and asynchronous active-high reset
//   mem_req_cmd_*            command channel (ready/valid): line addr, tag, rw
//   mem_req_data_*           write-beat channel (ready/valid)
//   mem_resp_*               read-beat channel (valid only, no backpressure)
//
// Every output is a flop. The array itself is never reset.

module mem_resp_model #(
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 5,
    parameter int DATA_WIDTH     = 128,
    parameter int REFILL_CYCLES  = 4,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req_cmd_ready,
    input  logic                  mem_req_cmd_valid,
    input  logic [ADDR_WIDTH-1:0] mem_req_cmd_bits_addr,
    input  logic [TAG_WIDTH-1:0]  mem_req_cmd_bits_tag,
    input  logic                  mem_req_cmd_bits_rw,
    output logic                  mem_req_data_ready,
    input  logic                  mem_req_data_valid,
    input  logic [DATA_WIDTH-1:0] mem_req_data_bits_data,
    output logic                  mem_resp_valid,
    output logic [DATA_WIDTH-1:0] mem_resp_bits_data,
    output logic [TAG_WIDTH-1:0]  mem_resp_bits_tag
);

    localparam int BEAT_W = $clog2(REFILL_CYCLES);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REFILL_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RWAIT,
        RDATA
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;

    logic                    cmd_ready_d;
    logic                    data_ready_d;
    logic                    resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_d;
    logic [TAG_WIDTH-1:0]    resp_tag_d;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [MEM_DEPTH_LOG2-1:0] mem_idx;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_we;

    // Word index is {line address, beat}; high bits simply fall off, so
    // lines alias modulo the array size.
    assign mem_idx   = MEM_DEPTH_LOG2'({addr_q, beat_q});
    assign mem_rdata = mem[mem_idx];

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that every port comes straight from a flop. In RWAIT/RDATA the beat
    // counter always points at the beat being loaded into the response
    // register; once it wraps back to zero every beat has been sent.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        cmd_ready_d  = 1'b0;
        data_ready_d = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = mem_resp_bits_data;
        resp_tag_d   = mem_resp_bits_tag;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                beat_d      = '0;
                lat_d       = '0;
                if (mem_req_cmd_valid && mem_req_cmd_ready) begin
                    addr_d      = mem_req_cmd_bits_addr;
                    tag_d       = mem_req_cmd_bits_tag;
                    cmd_ready_d = 1'b0;
                    if (mem_req_cmd_bits_rw) begin
                        state_d      = WDATA;
                        data_ready_d = 1'b1;
                    end else begin
                        state_d = RWAIT;
                    end
                end
            end

            WDATA: begin
                data_ready_d = 1'b1;
                if (mem_req_data_valid && mem_req_data_ready) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        data_ready_d = 1'b0;
                        cmd_ready_d  = 1'b1;
                    end
                end
            end

            RWAIT: begin
                if (lat_q == LAST_WAIT) begin
                    state_d      = RDATA;
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_rdata;
                    resp_tag_d   = tag_q;
                    beat_d       = beat_q + BEAT_W'(1);
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            RDATA: begin
                if (beat_q == '0) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_rdata;
                    resp_tag_d   = tag_q;
                    beat_d       = beat_q + BEAT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            beat_q             <= '0;
            lat_q              <= '0;
            addr_q             <= '0;
            tag_q              <= '0;
            mem_req_cmd_ready  <= 1'b0;
            mem_req_data_ready <= 1'b0;
            mem_resp_valid     <= 1'b0;
            mem_resp_bits_data <= '0;
            mem_resp_bits_tag  <= '0;
        end else begin
            state_q            <= state_d;
            beat_q             <= beat_d;
            lat_q              <= lat_d;
            addr_q             <= addr_d;
            tag_q              <= tag_d;
            mem_req_cmd_ready  <= cmd_ready_d;
            mem_req_data_ready <= data_ready_d;
            mem_resp_valid     <= resp_valid_d;
            mem_resp_bits_data <= resp_data_d;
            mem_resp_bits_tag  <= resp_tag_d;
        end
    end

    // Single-port array: reads and writes never happen in the same state, so
    // one shared index serves both. Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_req_data_bits_data;
        end
    end

endmodule

// File: tb/tb_mem_resp_model.sv
// tb_mem_resp_model
//
// Self-checking bench for mem_resp_model. A table of directed transactions is
// applied first, then hand-written multi-cycle sequences (write stalls, busy
// command, stray data, reset mid-read, back-to-back), then random traffic.
// Expected read data comes from a sparse array model indexed by
// (line * REFILL_CYCLES + beat) mod depth.

module tb_mem_resp_model;

    localparam int ADDR_WIDTH     = 26;
    localparam int TAG_WIDTH      = 5;
    localparam int DATA_WIDTH     = 128;
    localparam int REFILL_CYCLES  = 4;
    localparam int MEM_DEPTH_LOG2 = 10;
    localparam int READ_LATENCY   = 2;
    localparam int DEPTH          = 1 << MEM_DEPTH_LOG2;

    typedef logic [REFILL_CYCLES-1:0][DATA_WIDTH-1:0] line_t;

    typedef struct {
        bit                    rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]  tag;
        line_t                 beats;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  mem_req_cmd_ready;
    logic                  mem_req_cmd_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] mem_req_cmd_bits_addr = '0;
    logic [TAG_WIDTH-1:0]  mem_req_cmd_bits_tag = '0;
    logic                  mem_req_cmd_bits_rw = 1'b0;
    logic                  mem_req_data_ready;
    logic                  mem_req_data_valid = 1'b0;
    logic [DATA_WIDTH-1:0] mem_req_data_bits_data = '0;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_bits_data;
    logic [TAG_WIDTH-1:0]  mem_resp_bits_tag;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int                    resp_cyc[$];
    logic [DATA_WIDTH-1:0] resp_data[$];
    logic [TAG_WIDTH-1:0]  resp_tag[$];

    logic [DATA_WIDTH-1:0] model_mem [int];

    mem_resp_model #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TAG_WIDTH     (TAG_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .REFILL_CYCLES (REFILL_CYCLES),
        .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2),
        .READ_LATENCY  (READ_LATENCY)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .mem_req_cmd_ready     (mem_req_cmd_ready),
        .mem_req_cmd_valid     (mem_req_cmd_valid),
        .mem_req_cmd_bits_addr (mem_req_cmd_bits_addr),
        .mem_req_cmd_bits_tag  (mem_req_cmd_bits_tag),
        .mem_req_cmd_bits_rw   (mem_req_cmd_bits_rw),
        .mem_req_data_ready    (mem_req_data_ready),
        .mem_req_data_valid    (mem_req_data_valid),
        .mem_req_data_bits_data(mem_req_data_bits_data),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_bits_data    (mem_resp_bits_data),
        .mem_resp_bits_tag     (mem_resp_bits_tag)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge N (and until the next one) cyc equals N.
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor, sampled mid-cycle so each beat is tagged with the
    // edge that launched it.
    always @(negedge clk) begin
        if (mem_resp_valid === 1'b1) begin
            resp_cyc.push_back(cyc);
            resp_data.push_back(mem_resp_bits_data);
            resp_tag.push_back(mem_resp_bits_tag);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int idx_of(input logic [ADDR_WIDTH-1:0] addr, input int beat);
        longint a;
        a = longint'(addr);
        return int'((a * REFILL_CYCLES + beat) % DEPTH);
    endfunction

    function automatic bit line_known(input logic [ADDR_WIDTH-1:0] addr);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < REFILL_CYCLES; k++)
            if (!model_mem.exists(idx_of(addr, k))) ok = 1'b0;
        return ok;
    endfunction

    function automatic line_t model_line(input logic [ADDR_WIDTH-1:0] addr);
        line_t l;
        l = '0;
        for (int k = 0; k < REFILL_CYCLES; k++)
            if (model_mem.exists(idx_of(addr, k))) l[k] = model_mem[idx_of(addr, k)];
        return l;
    endfunction

    function automatic line_t random_line();
        line_t l;
        for (int k = 0; k < REFILL_CYCLES; k++)
            l[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_WIDTH-1:0] actual,
                               input logic [DATA_WIDTH-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    task automatic clear_resp();
        resp_cyc.delete();
        resp_data.delete();
        resp_tag.delete();
    endtask

    // Present a command and hold it until the DUT takes it; returns the edge
    // number of the handshake, or -1 on timeout.
    task automatic send_cmd(input bit rw, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [TAG_WIDTH-1:0] tag, output int accept);
        mem_req_cmd_valid     = 1'b1;
        mem_req_cmd_bits_rw   = rw;
        mem_req_cmd_bits_addr = addr;
        mem_req_cmd_bits_tag  = tag;
        accept = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_req_cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                accept = cyc;
                mem_req_cmd_valid = 1'b0;
                break;
            end
        end
        if (accept < 0) begin
            tests_run++;
            tests_failed++;
            mem_req_cmd_valid = 1'b0;
            $display("[TB] FAIL cmd_accept: actual no handshake in 200 cycles, required acceptance");
        end
    endtask

    // Drive write beats with a valid pattern (or random gaps); the model is
    // updated only on observed handshakes.
    task automatic send_data(input logic [ADDR_WIDTH-1:0] addr, input line_t beats,
                             input logic [15:0] pattern, input int plen, input bit rnd,
                             output int used, output int last_edge);
        int hs;
        bit v;
        bit fire;
        hs = 0;
        used = 0;
        while (hs < REFILL_CYCLES && used < 200) begin
            if (rnd) v = ($urandom_range(0, 2) != 0);
            else     v = (used < plen) ? pattern[used] : 1'b1;
            mem_req_data_valid     = v;
            mem_req_data_bits_data = beats[hs];
            @(negedge clk);
            fire = mem_req_data_valid && (mem_req_data_ready === 1'b1);
            checkOutput("cmd_ready_during_write", mem_req_cmd_ready, 1'b0);
            @(posedge clk);
            #1;
            used++;
            if (fire) begin
                model_mem[idx_of(addr, hs)] = beats[hs];
                hs++;
            end
        end
        mem_req_data_valid = 1'b0;
        last_edge = cyc;
        if (hs < REFILL_CYCLES) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL write_beats: actual %0d handshakes, required %0d", hs, REFILL_CYCLES);
        end
        checkOutput("cmd_ready_after_write", mem_req_cmd_ready, 1'b1);
        checkOutput("data_ready_after_write", mem_req_data_ready, 1'b0);
    endtask

    // Compare the captured beats against a read accepted at edge a.
    task automatic check_beats(input int a, input logic [TAG_WIDTH-1:0] tag, input line_t exp);
        int found;
        checkOutput("resp_beat_count", resp_cyc.size(), REFILL_CYCLES);
        for (int k = 0; k < REFILL_CYCLES; k++) begin
            found = -1;
            foreach (resp_cyc[j])
                if (resp_cyc[j] == a + READ_LATENCY + k) found = j;
            if (found < 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL resp_timing: actual beat %0d absent, required at edge %0d",
                         k, a + READ_LATENCY + k);
            end else begin
                checkOutput("resp_data", resp_data[found], exp[k]);
                checkOutput("resp_tag", resp_tag[found], tag);
            end
        end
        clear_resp();
    endtask

    task automatic finish_read(input int a, input logic [TAG_WIDTH-1:0] tag, input line_t exp);
        for (int n = 1; n <= READ_LATENCY + REFILL_CYCLES; n++) begin
            @(posedge clk);
            #1;
            if (n < READ_LATENCY + REFILL_CYCLES) begin
                checkOutput("cmd_ready_during_read", mem_req_cmd_ready, 1'b0);
            end else begin
                checkOutput("cmd_ready_after_read", mem_req_cmd_ready, 1'b1);
                checkOutput("resp_valid_after_read", mem_resp_valid, 1'b0);
            end
        end
        check_beats(a, tag, exp);
    endtask

    task automatic do_read(input logic [ADDR_WIDTH-1:0] addr, input logic [TAG_WIDTH-1:0] tag,
                           input line_t exp);
        int a;
        send_cmd(1'b0, addr, tag, a);
        finish_read(a, tag, exp);
    endtask

    task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [TAG_WIDTH-1:0] tag,
                            input line_t beats, input logic [15:0] pattern, input int plen,
                            input bit rnd);
        int a;
        int used;
        int last;
        send_cmd(1'b1, addr, tag, a);
        send_data(addr, beats, pattern, plen, rnd, used, last);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rw) do_write(v.addr, v.tag, v.beats, 16'hFFFF, 16, 1'b0);
        else      do_read(v.addr, v.tag, v.beats);
    endtask

    initial begin
        vec_t                  vecs[6];
        line_t                 wr;
        line_t                 exp;
        int                    a;
        int                    b;
        int                    used;
        int                    last;
        logic [ADDR_WIDTH-1:0] addr;

        // Directed table: write/read, then two lines that alias in the array.
        for (int k = 0; k < REFILL_CYCLES; k++) begin
            vecs[0].beats[k] = DATA_WIDTH'(8'hA0 + k);
            vecs[1].beats[k] = DATA_WIDTH'(8'hA0 + k);
            vecs[2].beats[k] = {16{8'h11}} ^ DATA_WIDTH'(k);
            vecs[3].beats[k] = {16{8'h22}} ^ DATA_WIDTH'(k);
            vecs[4].beats[k] = {16{8'h22}} ^ DATA_WIDTH'(k);
            vecs[5].beats[k] = {16{8'h22}} ^ DATA_WIDTH'(k);
        end
        vecs[0].rw = 1'b1; vecs[0].addr = 26'h005; vecs[0].tag = 5'd1;
        vecs[1].rw = 1'b0; vecs[1].addr = 26'h005; vecs[1].tag = 5'd3;
        vecs[2].rw = 1'b1; vecs[2].addr = 26'h005; vecs[2].tag = 5'd2;
        vecs[3].rw = 1'b1; vecs[3].addr = 26'h105; vecs[3].tag = 5'd4;
        vecs[4].rw = 1'b0; vecs[4].addr = 26'h005; vecs[4].tag = 5'd6;
        vecs[5].rw = 1'b0; vecs[5].addr = 26'h105; vecs[5].tag = 5'd7;

        // Reset state.
        #1;
        reset = 1'b1;
        #3;
        checkOutput("reset_cmd_ready", mem_req_cmd_ready, 1'b0);
        checkOutput("reset_data_ready", mem_req_data_ready, 1'b0);
        checkOutput("reset_resp_valid", mem_resp_valid, 1'b0);
        checkOutput("reset_resp_data", mem_resp_bits_data, '0);
        checkOutput("reset_resp_tag", mem_resp_bits_tag, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("cmd_ready_before_first_edge", mem_req_cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("cmd_ready_first_edge", mem_req_cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Write with stalls: valid pattern 1,0,0,1,1,0,1 gives exactly four beats.
        wr = random_line();
        send_cmd(1'b1, 26'h030, 5'd10, a);
        send_data(26'h030, wr, 16'b1011001, 7, 1'b0, used, last);
        checkOutput("stall_cycles_used", used, 7);
        do_read(26'h030, 5'd11, wr);

        // Read command held while a write is still collecting beats.
        wr = random_line();
        send_cmd(1'b1, 26'h007, 5'd12, a);
        mem_req_cmd_valid     = 1'b1;
        mem_req_cmd_bits_rw   = 1'b0;
        mem_req_cmd_bits_addr = 26'h007;
        mem_req_cmd_bits_tag  = 5'd13;
        send_data(26'h007, wr, 16'b11011, 5, 1'b0, used, last);
        send_cmd(1'b0, 26'h007, 5'd13, b);
        checkOutput("busy_accept_edge", b, last + 1);
        finish_read(b, 5'd13, wr);

        // Stray write beats while idle must not touch the array.
        for (int n = 0; n < 4; n++) begin
            mem_req_data_valid     = 1'b1;
            mem_req_data_bits_data = {4{32'hDEADBEEF}};
            @(negedge clk);
            checkOutput("data_ready_idle", mem_req_data_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        mem_req_data_valid = 1'b0;
        do_read(26'h007, 5'd14, wr);

        // Reset in the middle of a read, during beat 1.
        exp = model_line(26'h005);
        send_cmd(1'b0, 26'h005, 5'd15, a);
        repeat (READ_LATENCY + 1) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midread_resp_valid", mem_resp_valid, 1'b0);
        checkOutput("midread_cmd_ready", mem_req_cmd_ready, 1'b0);
        checkOutput("midread_resp_data", mem_resp_bits_data, '0);
        checkOutput("midread_beats_seen", resp_cyc.size(), 2);
        if (resp_cyc.size() == 2) checkOutput("midread_beat1", resp_data[1], exp[1]);
        clear_resp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("release_cmd_ready", mem_req_cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("release_cmd_ready_edge", mem_req_cmd_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("no_beats_after_release", resp_cyc.size(), 0);
        clear_resp();

        // Read immediately followed by a write to the same line, then a read.
        exp = model_line(26'h005);
        send_cmd(1'b0, 26'h005, 5'd16, a);
        send_cmd(1'b1, 26'h005, 5'd17, b);
        checkOutput("b2b_accept_edge", b, a + READ_LATENCY + REFILL_CYCLES + 1);
        check_beats(a, 5'd16, exp);
        wr = random_line();
        send_data(26'h005, wr, 16'h0, 0, 1'b1, used, last);
        do_read(26'h005, 5'd18, wr);

        // Random traffic over a few aliasing lines against the array model.
        for (int t = 0; t < 40; t++) begin
            addr = ADDR_WIDTH'($urandom_range(0, 7));
            if ($urandom_range(0, 1) != 0) addr = addr | 26'h100;
            if (line_known(addr) && ($urandom_range(0, 1) != 0))
                do_read(addr, TAG_WIDTH'($urandom_range(0, 31)), model_line(addr));
            else
                do_write(addr, TAG_WIDTH'($urandom_range(0, 31)), random_line(), 16'h0, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
